// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: start control, ROM port, decode handshake,
// branch redirect and status outputs.
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) ();
  logic               start_i;
  logic [PC_W-1:0]    start_addr_i;
  logic [PC_W-1:0]    pc_o;
  logic [INSTR_W-1:0] iptr_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic               br_taken_i;
  logic [PC_W-1:0]    br_target_i;
  logic               done_o;
  logic [CNT_W-1:0]   cycles_o;

  modport master (
    input  start_i, start_addr_i, iptr_i,
    input  instr_ready_i, br_taken_i, br_target_i,
    output pc_o, instr_o, instr_pc_o,
    output instr_valid_o, done_o, cycles_o
  );

  modport slave (
    output start_i, start_addr_i, iptr_i,
    output instr_ready_i, br_taken_i, br_target_i,
    input  pc_o, instr_o, instr_pc_o,
    input  instr_valid_o, done_o, cycles_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-word buffer to decode,
// branch flush, halt drain. Optional FETCH_CYCLE_CNT_EN counter.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter logic [INSTR_W-1:0] HALT_WORD = '0,
  parameter int CNT_W   = 16
) (
  input logic         Clk,
  input logic         Reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               valid;
  logic               done;

  logic go, flush, load, fin, is_halt;

  assign is_halt = (bus.iptr_i == HALT_WORD);

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and datapath actions; branch beats load/halt
  always_comb begin
    state_n = state;
    go      = 1'b0;
    flush   = 1'b0;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          go      = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.br_taken_i) begin
          flush = 1'b1;
        end else if (!valid || bus.instr_ready_i) begin
          load = 1'b1;
          if (is_halt) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.br_taken_i) begin
          flush   = 1'b1;
          state_n = RUN;
        end else if (valid && bus.instr_ready_i) begin
          fin     = 1'b1;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // PC, instruction buffer and done flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc       <= '0;
      instr    <= '0;
      instr_pc <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else if (go) begin
      pc    <= bus.start_addr_i;
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      pc    <= bus.br_target_i;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= bus.iptr_i;
      instr_pc <= pc;
      valid    <= 1'b1;
      if (!is_halt) pc <= pc + PC_W'(1);
    end else if (fin) begin
      valid <= 1'b0;
      done  <= 1'b1;
    end
  end

  assign bus.pc_o          = pc;
  assign bus.instr_o       = instr;
  assign bus.instr_pc_o    = instr_pc;
  assign bus.instr_valid_o = valid;
  assign bus.done_o        = done;

`ifdef FETCH_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // saturating count of RUN/DRAIN cycles
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (go) begin
      cnt <= '0;
    end else if ((state == RUN || state == DRAIN) &&
                 cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.cycles_o = cnt;
`else
  assign bus.cycles_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// random ready/branch traffic checked against a stream model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [8:0] rom [256];
  assign bus.iptr_i = rom[bus.pc_o];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_pc;
  int         accepted;
  logic       rdy, br;
  logic [7:0] tgt;

  initial begin
    bus.start_i       = 1'b0;
    bus.start_addr_i  = '0;
    bus.instr_ready_i = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.br_target_i   = '0;
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(1, 511));

    // reset state
    step(); step();
    check("rst_pc", 32'(bus.pc_o), 0);
    check("rst_valid", 32'(bus.instr_valid_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_instr", 32'(bus.instr_o), 0);
    check("rst_ipc", 32'(bus.instr_pc_o), 0);
    check("rst_cycles", 32'(bus.cycles_o), 0);
    rst = 1'b0;
    step();

    // start at 25, sustained flow
    bus.start_i = 1'b1; bus.start_addr_i = 8'd25;
    bus.instr_ready_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    check("start_pc", 32'(bus.pc_o), 25);
    check("start_valid", 32'(bus.instr_valid_o), 0);
    step();
    check("first_ipc", 32'(bus.instr_pc_o), 25);
    check("first_word", 32'(bus.instr_o), 32'(rom[25]));
    check("first_valid", 32'(bus.instr_valid_o), 1);
    check("first_pc", 32'(bus.pc_o), 26);
    step();
    check("second_ipc", 32'(bus.instr_pc_o), 26);
    check("second_pc", 32'(bus.pc_o), 27);

    // stall three cycles; start_i in RUN must be ignored
    bus.instr_ready_i = 1'b0;
    bus.start_i = 1'b1; bus.start_addr_i = 8'd99;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.start_i = 1'b0;
      check("stall_ipc", 32'(bus.instr_pc_o), 26);
      check("stall_word", 32'(bus.instr_o), 32'(rom[26]));
      check("stall_pc", 32'(bus.pc_o), 27);
      check("stall_valid", 32'(bus.instr_valid_o), 1);
    end
    bus.instr_ready_i = 1'b1;
    step();
    check("resume_ipc", 32'(bus.instr_pc_o), 27);
    check("resume_pc", 32'(bus.pc_o), 28);

    // branch to 45 while word 30 is buffered
    for (int k = 0; k < 10 && bus.instr_pc_o != 8'd30; k++) step();
    check("reach_30", 32'(bus.instr_pc_o), 30);
    bus.br_taken_i = 1'b1; bus.br_target_i = 8'd45;
    step();
    bus.br_taken_i = 1'b0;
    check("br_valid", 32'(bus.instr_valid_o), 0);
    check("br_pc", 32'(bus.pc_o), 45);
    step();
    check("br_ipc", 32'(bus.instr_pc_o), 45);
    check("br_word", 32'(bus.instr_o), 32'(rom[45]));
    check("br_valid2", 32'(bus.instr_valid_o), 1);
    step();
    check("br_next", 32'(bus.instr_pc_o), 46);

    // random traffic from 250 (crosses wrap) vs stream model
    rst = 1'b1; step(); rst = 1'b0;
    bus.start_i = 1'b1; bus.start_addr_i = 8'd250;
    step();
    bus.start_i = 1'b0;
    exp_pc = 8'd250;
    accepted = 0;
    for (int k = 0; k < 300; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      tgt = 8'($urandom);
      bus.instr_ready_i = rdy;
      bus.br_taken_i    = br;
      bus.br_target_i   = tgt;
      if (br) begin
        exp_pc = tgt;
      end else if (bus.instr_valid_o && rdy) begin
        check("rnd_ipc", 32'(bus.instr_pc_o), 32'(exp_pc));
        check("rnd_word", 32'(bus.instr_o), 32'(rom[exp_pc]));
        exp_pc = exp_pc + 8'd1;
        accepted++;
      end
      step();
    end
    bus.br_taken_i = 1'b0;
    check("rnd_progress", 32'(accepted > 100), 1);

    // reset mid-RUN
    rst = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.instr_valid_o), 0);
    check("mid_rst_pc", 32'(bus.pc_o), 0);
    check("mid_rst_done", 32'(bus.done_o), 0);
    step();
    check("idle_pc", 32'(bus.pc_o), 0);
    check("idle_valid", 32'(bus.instr_valid_o), 0);

    // halt word at 24, run from 20
    rom[24] = 9'd0;
    bus.instr_ready_i = 1'b1;
    bus.start_i = 1'b1; bus.start_addr_i = 8'd20;
    step();
    bus.start_i = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("halt_ipc", 32'(bus.instr_pc_o), 24);
    check("halt_word", 32'(bus.instr_o), 0);
    check("halt_pc", 32'(bus.pc_o), 24);
    check("halt_valid", 32'(bus.instr_valid_o), 1);
    bus.instr_ready_i = 1'b0;
    step();
    check("drain_valid", 32'(bus.instr_valid_o), 1);
    check("drain_pc", 32'(bus.pc_o), 24);
    check("drain_done", 32'(bus.done_o), 0);
    bus.instr_ready_i = 1'b1;
    step();
    check("done_done", 32'(bus.done_o), 1);
    check("done_valid", 32'(bus.instr_valid_o), 0);

    // cycle count: start 0, halt at 24
    rst = 1'b1; step(); rst = 1'b0;
    bus.start_i = 1'b1; bus.start_addr_i = 8'd0;
    step();
    bus.start_i = 1'b0;
    for (int k = 0; k < 100 && !bus.done_o; k++) step();
    check("cnt_done", 32'(bus.done_o), 1);
`ifdef FETCH_CYCLE_CNT_EN
    check("cnt_cycles", 32'(bus.cycles_o), 26);
`else
    check("cnt_cycles", 32'(bus.cycles_o), 0);
`endif

    // restart at 44 where the halt word sits
    rom[44] = 9'd0;
    bus.start_i = 1'b1; bus.start_addr_i = 8'd44;
    step();
    bus.start_i = 1'b0;
    check("re_done", 32'(bus.done_o), 0);
    check("re_pc", 32'(bus.pc_o), 44);
    check("re_cycles", 32'(bus.cycles_o), 0);
    step();
    check("h44_ipc", 32'(bus.instr_pc_o), 44);
    check("h44_valid", 32'(bus.instr_valid_o), 1);
    check("h44_pc", 32'(bus.pc_o), 44);
    step();
    check("h44_done", 32'(bus.done_o), 1);
    check("h44_valid2", 32'(bus.instr_valid_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
